// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - Default width/depth constants for DATA_W, ADDR_W and DEPTH_LOG2.
//   - FSM state enum: StIdle (IDLE), StRead (READ), StResp (RESP).
package dmem_pkg;

  localparam int unsigned DefaultDataW     = 16;
  localparam int unsigned DefaultAddrW     = 16;
  localparam int unsigned DefaultDepthLog2 = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StResp = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/data_mem_resp_if.sv
// Request/response bus between the CPU and the data-memory responder.
// Ports: none. The signals are grouped as follows:
//   req_valid, req_we, req_addr, req_wdata  CPU -> responder request
//   req_ready                               responder -> CPU accept
//   rsp_valid, rsp_rdata, rsp_err           responder -> CPU response
//   rsp_ready                               CPU -> responder consume
// Modports: master (CPU side) and slave (responder side).
interface data_mem_resp_if #(
  parameter int unsigned DATA_W = dmem_pkg::DefaultDataW,
  parameter int unsigned ADDR_W = dmem_pkg::DefaultAddrW
);

  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port data storage: synchronous write, registered read, no reset.
// Ports:
//   clk    clock
//   we     write enable (writes wdata to addr at the rising edge)
//   re     read enable (loads rdata register from addr at the rising edge)
//   addr   word index
//   wdata  write data
//   rdata  registered read data, holds until the next read
module dmem_array #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one load/store at a time from the CPU and
// returns a response that is held until the CPU consumes it.
//   Store: IDLE -> RESP (response the cycle after acceptance).
//   Load:  IDLE -> READ -> RESP (response two cycles after acceptance).
// Ports:
//   clk    clock, all state changes on its rising edge
//   reset  asynchronous active-low reset (storage is not cleared)
//   bus    data_mem_resp_if slave modport (request/response handshake)
// Optional feature: define DMEM_ERR_EN to flag requests whose address has
// any bit set above DEPTH_LOG2-1 (no write, rdata 0, rsp_err 1). Without it
// the upper address bits are ignored and rsp_err stays 0.
// Assumes ADDR_W > DEPTH_LOG2 and bus widths matching DATA_W/ADDR_W.
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned ADDR_W     = DefaultAddrW,
  parameter int unsigned DEPTH_LOG2 = DefaultDepthLog2
) (
  input logic             clk,
  input logic             reset,
  data_mem_resp_if.slave  bus
);

  dmem_state_e       state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              err_q;

  logic              accept;
  logic              addr_err;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_ERR_EN
  assign addr_err = |bus.req_addr[ADDR_W-1:DEPTH_LOG2];
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^bus.req_addr[ADDR_W-1:DEPTH_LOG2];
  assign addr_err          = 1'b0;
`endif

  // req_ready_q is only ever set in StIdle, so it alone qualifies acceptance;
  // it is 0 under reset, which also keeps the array quiet during reset.
  assign accept = bus.req_valid & req_ready_q;

  // The array is driven straight from the request at acceptance, so the
  // transaction is fixed at that edge and later input changes cannot leak in.
  assign mem_we = accept & bus.req_we & ~addr_err;
  assign mem_re = accept & ~bus.req_we;

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_dmem_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (bus.req_addr[DEPTH_LOG2-1:0]),
    .wdata (bus.req_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            err_q       <= addr_err;
            if (bus.req_we) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= addr_err;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= err_q ? '0 : mem_rdata;
          rsp_err_q   <= err_q;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: a transaction-level model predicts
// req_ready/rsp_valid/rsp_rdata/rsp_err every cycle, plus directed scenarios
// with literal expectations. Honours DMEM_ERR_EN when defined.
module tb_data_mem_resp;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned DL = 8;
  localparam int unsigned NW = 1 << DL;
`ifdef DMEM_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_resp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_mem_resp #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .DEPTH_LOG2 (DL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: memory contents plus the visible state of one outstanding transaction.
  logic [DW-1:0] m_mem [NW];
  bit            m_ready, m_valid, m_err, m_busy, p_err, m_acc;
  logic [DW-1:0] m_rdata, p_rdata;
  int            m_wait, acc_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
    chk("rsp_err",   32'(bus.rsp_err),   32'(m_err));
  endtask

  function automatic void model_reset();
    m_ready = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    m_rdata = '0;   m_wait  = 0;    m_acc = 1'b0;
  endfunction

  // One clock edge of the transaction rules: store responds 1 cycle after
  // acceptance, load 2; the response holds until consumed; ready returns next.
  function automatic void model_step();
    int idx;
    bit err;
    m_acc = 1'b0;
    if (reset == 1'b0) return;
    if (m_ready) begin
      if (bus.req_valid) begin
        idx     = int'(bus.req_addr[DL-1:0]);
        err     = ErrEn && (bus.req_addr[AW-1:DL] != '0);
        m_acc   = 1'b1;
        acc_cyc = cyc;
        m_ready = 1'b0;
        m_busy  = 1'b1;
        p_err   = err;
        if (bus.req_we) begin
          if (!err) m_mem[idx] = bus.req_wdata;
          p_rdata = '0;
          m_wait  = 0;
        end else begin
          p_rdata = err ? '0 : m_mem[idx];
          m_wait  = 1;
        end
        if (m_wait == 0) begin
          m_valid = 1'b1; m_rdata = p_rdata; m_err = p_err;
        end
      end
    end else if (!m_busy) begin
      m_ready = 1'b1;
    end else if (m_valid) begin
      if (bus.rsp_ready) begin
        m_valid = 1'b0; m_busy = 1'b0; m_ready = 1'b1; m_rdata = '0; m_err = 1'b0;
      end
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1; m_rdata = p_rdata; m_err = p_err;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       output int acc);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_acc) begin
        acc = acc_cyc;
        break;
      end
    end
    bus.req_valid = 1'b0;
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout cyc=%0d actual=not_accepted required=accepted", cyc);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b1;
  endtask

  int a, b, c;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    reset         = 1'b0;
    model_reset();
    for (int i = 0; i < int'(NW); i++) m_mem[i] = '0;

    repeat (2) cycle();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    cycle();
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Fill every word with a known pattern: i*0x0101 ^ 0x5A5A.
    for (int i = 0; i < int'(NW); i++) begin
      issue(1'b1, 16'(i), 16'(i * 16'h0101) ^ 16'h5A5A, a);
    end

    // Store then load at address 5.
    issue(1'b1, 16'h0005, 16'h1234, a);
    chk("st_rsp_valid_n1", 32'(bus.rsp_valid), 32'd1);
    chk("st_rsp_rdata0",   32'(bus.rsp_rdata), 32'd0);
    cycle();
    issue(1'b0, 16'h0005, 16'h0000, a);
    chk("ld_not_valid_n1", 32'(bus.rsp_valid), 32'd0);
    cycle();
    chk("ld_valid_n2", 32'(bus.rsp_valid), 32'd1);
    chk("ld_rdata_n2", 32'(bus.rsp_rdata), 32'h1234);
    chk("ld_err_n2",   32'(bus.rsp_err),   32'd0);

    // Response stall for 4 cycles.
    cycle();
    bus.rsp_ready = 1'b0;
    issue(1'b0, 16'h0005, 16'h0000, a);
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rdata", 32'(bus.rsp_rdata), 32'h1234);
      chk("stall_ready", 32'(bus.req_ready), 32'd0);
      cycle();
    end
    bus.rsp_ready = 1'b1;
    cycle();
    chk("stall_release_ready", 32'(bus.req_ready), 32'd1);
    chk("stall_release_valid", 32'(bus.rsp_valid), 32'd0);

    // Upper address bits: 0x01FF aliases 0x00FF unless errors are enabled.
    issue(1'b1, 16'h00FF, 16'h0F0F, a);
    cycle();
    issue(1'b0, 16'h01FF, 16'h0000, a);
    cycle();
`ifdef DMEM_ERR_EN
    chk("oor_ld_err",   32'(bus.rsp_err),   32'd1);
    chk("oor_ld_rdata", 32'(bus.rsp_rdata), 32'd0);
`else
    chk("wrap_ld_err",   32'(bus.rsp_err),   32'd0);
    chk("wrap_ld_rdata", 32'(bus.rsp_rdata), 32'h0F0F);
`endif
    cycle();
    issue(1'b1, 16'h01FF, 16'h7777, a);
`ifdef DMEM_ERR_EN
    chk("oor_st_err", 32'(bus.rsp_err), 32'd1);
`else
    chk("wrap_st_err", 32'(bus.rsp_err), 32'd0);
`endif
    cycle();
    issue(1'b0, 16'h00FF, 16'h0000, a);
    cycle();
`ifdef DMEM_ERR_EN
    chk("oor_no_write", 32'(bus.rsp_rdata), 32'h0F0F);
`else
    chk("wrap_write", 32'(bus.rsp_rdata), 32'h7777);
`endif
    cycle();

    // Reset while a load sits in READ.
    issue(1'b1, 16'h0030, 16'hCAFE, a);
    cycle();
    issue(1'b0, 16'h0030, 16'h0000, a);
    do_reset(2);
    cycle();
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b0, 16'h0030, 16'h0000, a);
    cycle();
    chk("post_rst_rdata", 32'(bus.rsp_rdata), 32'hCAFE);
    cycle();

    // Inputs change right after a store is accepted.
    issue(1'b1, 16'h0010, 16'hBEEF, a);
    bus.req_addr  = 16'h0011;
    bus.req_wdata = 16'h5555;
    cycle();
    issue(1'b0, 16'h0010, 16'h0000, a);
    cycle();
    chk("capture_0010", 32'(bus.rsp_rdata), 32'hBEEF);
    cycle();
    issue(1'b0, 16'h0011, 16'h0000, a);
    cycle();
    chk("capture_0011", 32'(bus.rsp_rdata), 32'h4B4B);
    cycle();

    // Back-to-back throughput with rsp_ready held high.
    issue(1'b1, 16'h0020, 16'h1111, a);
    issue(1'b1, 16'h0021, 16'h2222, b);
    issue(1'b0, 16'h0020, 16'h0000, c);
    cycle();
    chk("b2b_rdata",   32'(bus.rsp_rdata), 32'h1111);
    chk("b2b_space_1", 32'(b - a), 32'd2);
    chk("b2b_space_2", 32'(c - b), 32'd2);
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid = ($urandom_range(0, 9) < 7);
      bus.req_we    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) bus.req_addr = 16'($urandom);
      else                            bus.req_addr = 16'($urandom_range(0, 511));
      bus.req_wdata = 16'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) do_reset(1 + int'($urandom_range(0, 1)));
      else                             cycle();
    end

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
